// File: rtl/zeroriscy_bnn_seq.sv
// Sequencer for the bnn unit. It produces one output word of activations per run.
// A run issues this command sequence:
//   ini, then (pool_cnt+1) x { acc x acc_cnt, pool }, then norm, then activ.
// After activ it waits two cycles for the activation sign bits to settle, then
// captures them into result_o.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   start_i, abort_i       run request (sampled in IDLE only); cancel the current run
//   cfg_*_i                weight/norm row bases, acc words per window, pool windows-1
//   din_*                  activation input stream (valid/ready handshake)
//   bnn_*                  command interface to the bnn unit (en/ready handshake)
//   busy_o, done_o         run active; one-cycle completion pulse
//   result_o               activation bits captured at the end of a run
module zeroriscy_bnn_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] cfg_wbase_i,
    input  logic [15:0] cfg_nbase_i,
    input  logic [7:0]  cfg_acc_cnt_i,
    input  logic [1:0]  cfg_pool_cnt_i,
    input  logic        din_valid_i,
    input  logic [31:0] din_data_i,
    output logic        din_ready_o,
    output logic        bnn_en_o,
    output logic [2:0]  bnn_operator_o,
    output logic [31:0] bnn_addr_o,
    output logic [31:0] bnn_data_o,
    output logic [6:0]  bnn_param_o,
    input  logic        bnn_ready_i,
    input  logic [31:0] bnn_result_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [2:0] {
        StIdle, StIni, StAcc, StPool, StNorm, StActiv, StWait, StDone
    } state_e;

    localparam logic [2:0] OpIni   = 3'd0;
    localparam logic [2:0] OpAcc   = 3'd1;
    localparam logic [2:0] OpPool  = 3'd2;
    localparam logic [2:0] OpNorm  = 3'd3;
    localparam logic [2:0] OpActiv = 3'd4;

    state_e      state_q, state_d;
    logic [1:0]  p_q, p_d;
    logic [7:0]  k_q, k_d;
    logic [1:0]  wait_q, wait_d;
    logic [15:0] wbase_q, wbase_d;
    logic [15:0] nbase_q, nbase_d;
    logic [7:0]  acc_cnt_q, acc_cnt_d;
    logic [1:0]  pool_cnt_q, pool_cnt_d;
    logic [31:0] result_q, result_d;

    logic        cmd_valid;
    logic [15:0] cmd_row;
    logic        accept;

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        k_d        = k_q;
        wait_d     = wait_q;
        wbase_d    = wbase_q;
        nbase_d    = nbase_q;
        acc_cnt_d  = acc_cnt_q;
        pool_cnt_d = pool_cnt_q;
        result_d   = result_q;
        cmd_valid  = 1'b0;
        cmd_row    = 16'h0;
        bnn_operator_o = OpIni;
        bnn_data_o     = 32'h0;
        done_o         = 1'b0;

        // Command fields depend only on state and latched config, so they stay
        // stable while a command is held off by bnn_ready_i.
        unique case (state_q)
            StIni:   cmd_valid = 1'b1;
            StAcc: begin
                cmd_valid      = din_valid_i;
                bnn_operator_o = OpAcc;
                cmd_row        = wbase_q + {8'h0, k_q};
                bnn_data_o     = din_data_i;
            end
            StPool: begin
                cmd_valid      = 1'b1;
                bnn_operator_o = OpPool;
            end
            StNorm: begin
                cmd_valid      = 1'b1;
                bnn_operator_o = OpNorm;
                cmd_row        = nbase_q;
            end
            StActiv: begin
                cmd_valid      = 1'b1;
                bnn_operator_o = OpActiv;
            end
            default: ;
        endcase

        // Abort and reset kill the command in the same cycle.
        bnn_en_o    = cmd_valid & ~abort_i & ~rst;
        accept      = bnn_en_o & bnn_ready_i;
        din_ready_o = (state_q == StAcc) & accept;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    wbase_d    = cfg_wbase_i;
                    nbase_d    = cfg_nbase_i;
                    acc_cnt_d  = cfg_acc_cnt_i;
                    pool_cnt_d = cfg_pool_cnt_i;
                    p_d        = 2'd0;
                    k_d        = 8'd0;
                    state_d    = StIni;
                end
            end
            StIni: begin
                if (accept) state_d = (acc_cnt_q == 8'd0) ? StPool : StAcc;
            end
            StAcc: begin
                if (accept) begin
                    if (k_q == acc_cnt_q - 8'd1) begin
                        k_d     = 8'd0;
                        state_d = StPool;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end
            StPool: begin
                // The pool op reloads acc itself, so the next window skips ini.
                if (accept) begin
                    if (p_q == pool_cnt_q) begin
                        state_d = StNorm;
                    end else begin
                        p_d     = p_q + 2'd1;
                        state_d = (acc_cnt_q == 8'd0) ? StPool : StAcc;
                    end
                end
            end
            StNorm: begin
                if (accept) state_d = StActiv;
            end
            StActiv: begin
                if (accept) begin
                    wait_d  = 2'd2;
                    state_d = StWait;
                end
            end
            StWait: begin
                wait_d = wait_q - 2'd1;
                if (wait_q == 2'd1) state_d = StDone;
            end
            StDone: begin
                result_d = bnn_result_i;
                done_o   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort_i) begin
            state_d  = StIdle;
            result_d = result_q;
            done_o   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            p_q        <= 2'd0;
            k_q        <= 8'd0;
            wait_q     <= 2'd0;
            wbase_q    <= 16'h0;
            nbase_q    <= 16'h0;
            acc_cnt_q  <= 8'd0;
            pool_cnt_q <= 2'd0;
            result_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            k_q        <= k_d;
            wait_q     <= wait_d;
            wbase_q    <= wbase_d;
            nbase_q    <= nbase_d;
            acc_cnt_q  <= acc_cnt_d;
            pool_cnt_q <= pool_cnt_d;
            result_q   <= result_d;
        end
    end

    assign bnn_addr_o  = {16'h0, cmd_row};
    assign bnn_param_o = 7'h0;
    assign busy_o      = (state_q != StIdle);
    assign result_o    = result_q;

endmodule
